// File: rtl/axi_reg_master_if.sv
// axi_reg_master_if: AXI bus bundle shared by the register master and its slaves.
interface AXI_INF;
   logic [3:0]  WR_ADDR_ID;
   logic [31:0] WR_ADDR_ADDR;
   logic [7:0]  WR_ADDR_LEN;
   logic [1:0]  WR_ADDR_BURST;
   logic        WR_ADDR_VALID;
   logic        WR_ADDR_READY;
   logic [31:0] WR_DATA_DATA;
   logic        WR_DATA_VALID;
   logic        WR_DATA_READY;
   logic        WR_DATA_LAST;
   logic [3:0]  WR_BACK_ID;
   logic [1:0]  WR_BACK_RESP;
   logic        WR_BACK_VALID;
   logic        WR_BACK_READY;
   logic [3:0]  RD_ADDR_ID;
   logic [31:0] RD_ADDR_ADDR;
   logic [7:0]  RD_ADDR_LEN;
   logic [1:0]  RD_ADDR_BURST;
   logic        RD_ADDR_VALID;
   logic        RD_ADDR_READY;
   logic [3:0]  RD_BACK_ID;
   logic [31:0] RD_DATA_DATA;
   logic [1:0]  RD_DATA_RESP;
   logic        RD_DATA_VALID;
   logic        RD_DATA_READY;
   logic        RD_DATA_LAST;
   modport M (
      output WR_ADDR_ID, WR_ADDR_ADDR, WR_ADDR_LEN, WR_ADDR_BURST, WR_ADDR_VALID,
      input  WR_ADDR_READY,
      output WR_DATA_DATA, WR_DATA_VALID, WR_DATA_LAST,
      input  WR_DATA_READY,
      input  WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID,
      output WR_BACK_READY,
      output RD_ADDR_ID, RD_ADDR_ADDR, RD_ADDR_LEN, RD_ADDR_BURST, RD_ADDR_VALID,
      input  RD_ADDR_READY,
      input  RD_BACK_ID, RD_DATA_DATA, RD_DATA_RESP, RD_DATA_VALID, RD_DATA_LAST,
      output RD_DATA_READY
   );
endinterface

// File: rtl/axi_reg_master.sv
// axi_reg_master: single-outstanding AXI initiator turning local register commands
// into write/read bursts, with a one-cycle completion pulse carrying merged status.
module axi_reg_master #(
   parameter logic [3:0] MASTER_ID = 4'h0,
   parameter bit         CHECK_ID  = 1'b1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [7:0]  cmd_len,
   input  logic [1:0]  cmd_burst,
   input  logic [31:0] wdata,
   input  logic        wdata_valid,
   output logic        wdata_ready,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        rdata_last,
   input  logic        rdata_ready,
   output logic        done_valid,
   output logic        done_write,
   output logic [1:0]  done_resp,
   AXI_INF.M           AXI_M
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR_ADDR = 3'd1;
   localparam logic [2:0] WR_DATA = 3'd2;
   localparam logic [2:0] WR_RESP = 3'd3;
   localparam logic [2:0] RD_ADDR = 3'd4;
   localparam logic [2:0] RD_DATA = 3'd5;
   localparam logic [2:0] DONE    = 3'd6;

   logic        rstn_meta, rstn_sync;
   logic [2:0]  state;
   logic [31:0] addr_q;
   logic [7:0]  len_q, beat_cnt;
   logic [1:0]  burst_q, acc, r_resp;
   logic        write_q, last_beat, w_hs, r_hs, r_bad, b_bad;

   function automatic logic [1:0] rmax(input logic [1:0] a, input logic [1:0] b);
      return a > b ? a : b;
   endfunction

   // reset asserts asynchronously, releases two clocks later
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) {rstn_sync, rstn_meta} <= 2'b00;
      else       {rstn_sync, rstn_meta} <= {rstn_meta, 1'b1};

   assign last_beat = beat_cnt == len_q;
   assign w_hs      = state == WR_DATA && wdata_valid && AXI_M.WR_DATA_READY;
   assign r_hs      = state == RD_DATA && AXI_M.RD_DATA_VALID && rdata_ready;
   assign b_bad     = CHECK_ID && AXI_M.WR_BACK_ID != MASTER_ID;
   // a LAST that disagrees with the beat count in either direction is a slave error
   assign r_bad     = (AXI_M.RD_DATA_LAST != last_beat) || (CHECK_ID && AXI_M.RD_BACK_ID != MASTER_ID);
   assign r_resp    = rmax(rmax(acc, AXI_M.RD_DATA_RESP), {r_bad, 1'b0});

   assign cmd_ready   = state == IDLE && rstn_sync;
   assign wdata_ready = state == WR_DATA && AXI_M.WR_DATA_READY;
   assign rdata       = AXI_M.RD_DATA_DATA;
   assign rdata_valid = state == RD_DATA && AXI_M.RD_DATA_VALID;
   assign rdata_last  = state == RD_DATA && last_beat;
   assign done_valid  = state == DONE;
   assign done_write  = write_q;
   assign done_resp   = acc;

   assign AXI_M.WR_ADDR_ID    = MASTER_ID;
   assign AXI_M.WR_ADDR_ADDR  = addr_q;
   assign AXI_M.WR_ADDR_LEN   = len_q;
   assign AXI_M.WR_ADDR_BURST = burst_q;
   assign AXI_M.WR_ADDR_VALID = state == WR_ADDR;
   assign AXI_M.WR_DATA_DATA  = wdata;
   assign AXI_M.WR_DATA_VALID = state == WR_DATA && wdata_valid;
   assign AXI_M.WR_DATA_LAST  = state == WR_DATA && last_beat;
   assign AXI_M.WR_BACK_READY = state == WR_RESP;
   assign AXI_M.RD_ADDR_ID    = MASTER_ID;
   assign AXI_M.RD_ADDR_ADDR  = addr_q;
   assign AXI_M.RD_ADDR_LEN   = len_q;
   assign AXI_M.RD_ADDR_BURST = burst_q;
   assign AXI_M.RD_ADDR_VALID = state == RD_ADDR;
   assign AXI_M.RD_DATA_READY = state == RD_DATA && rdata_ready;

   always_ff @(posedge clk or negedge rstn_sync)
      if (!rstn_sync) begin
         state    <= IDLE;
         addr_q   <= '0;
         len_q    <= '0;
         burst_q  <= '0;
         write_q  <= 1'b0;
         beat_cnt <= '0;
         acc      <= '0;
      end else begin
         case (state)
            IDLE: if (cmd_valid) begin
               addr_q  <= cmd_addr;
               len_q   <= cmd_len;
               burst_q <= cmd_burst;
               write_q <= cmd_write;
               state   <= cmd_write ? WR_ADDR : RD_ADDR;
            end
            WR_ADDR: if (AXI_M.WR_ADDR_READY) state <= WR_DATA;
            WR_DATA: if (w_hs) begin
               beat_cnt <= beat_cnt + 8'd1;
               if (last_beat) state <= WR_RESP;
            end
            WR_RESP: if (AXI_M.WR_BACK_VALID) begin
               acc   <= b_bad ? 2'b10 : AXI_M.WR_BACK_RESP;
               state <= DONE;
            end
            RD_ADDR: if (AXI_M.RD_ADDR_READY) state <= RD_DATA;
            RD_DATA: if (r_hs) begin
               acc      <= r_resp;
               beat_cnt <= beat_cnt + 8'd1;
               if (AXI_M.RD_DATA_LAST) state <= DONE;
            end
            DONE: begin
               acc      <= '0;
               beat_cnt <= '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_axi_reg_master.sv
// tb_axi_reg_master: directed scenarios for axi_reg_master against a scripted AXI slave.
module tb_axi_reg_master;
   localparam int BOUND = 600;
   localparam int NONE  = 100000;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [1:0]  cmd_burst;
   logic [31:0] wdata, rdata;
   logic        wdata_valid, wdata_ready, rdata_valid, rdata_last, rdata_ready;
   logic        done_valid, done_write;
   logic [1:0]  done_resp;

   int n_chk = 0;
   int n_fail = 0;

   int          obs_beats, obs_last_at, obs_last_cnt, obs_data_err, obs_mirror_err;
   int          obs_stall, obs_stall_err, obs_addr_hs;
   logic [31:0] obs_addr;
   logic [7:0]  obs_len;
   logic        obs_acc, obs_done, obs_dw, obs_after;
   logic [1:0]  obs_resp;

   AXI_INF axi();

   axi_reg_master #(.MASTER_ID(4'h0), .CHECK_ID(1'b1)) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_burst(cmd_burst),
      .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
      .rdata(rdata), .rdata_valid(rdata_valid), .rdata_last(rdata_last), .rdata_ready(rdata_ready),
      .done_valid(done_valid), .done_write(done_write), .done_resp(done_resp),
      .AXI_M(axi)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_obs;
      obs_beats = 0; obs_last_at = 0; obs_last_cnt = 0; obs_data_err = 0; obs_mirror_err = 0;
      obs_stall = 0; obs_stall_err = 0; obs_addr_hs = 0; obs_addr = '0; obs_len = '0;
      obs_acc = 1'b0; obs_done = 1'b0; obs_dw = 1'b0; obs_after = 1'b0; obs_resp = 2'b00;
   endtask

   // Stimulus only: runs one write command and records what the bus showed.
   task automatic run_write(input logic [31:0] a, input logic [7:0] l, input bit tog,
                            input logic [1:0] br, input logic [3:0] bid);
      clear_obs();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = l; cmd_burst = 2'b01;
      wdata_valid = 1'b0; axi.WR_BACK_RESP = br; axi.WR_BACK_ID = bid;
      #1 obs_acc = cmd_ready;
      for (int cyc = 0; cyc < BOUND && !obs_done; cyc++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         wdata_valid = tog ? cyc[0] : 1'b1;
         axi.WR_DATA_READY = tog ? (cyc % 3 != 2) : 1'b1;
         wdata = 32'hA000_0000 + obs_beats;
         #1;
         if (axi.WR_ADDR_VALID && axi.WR_ADDR_READY) begin
            obs_addr_hs++; obs_addr = axi.WR_ADDR_ADDR; obs_len = axi.WR_ADDR_LEN;
         end
         if (axi.WR_DATA_VALID && wdata_ready !== axi.WR_DATA_READY) obs_mirror_err++;
         if (axi.WR_DATA_VALID && axi.WR_DATA_READY) begin
            if (axi.WR_DATA_DATA !== 32'hA000_0000 + obs_beats) obs_data_err++;
            obs_beats++;
            if (axi.WR_DATA_LAST) begin obs_last_cnt++; obs_last_at = obs_beats; end
         end
         if (done_valid) begin obs_done = 1'b1; obs_resp = done_resp; obs_dw = done_write; end
      end
      axi.WR_DATA_READY = 1'b1; wdata_valid = 1'b0;
      @(negedge clk); #1 obs_after = done_valid;
   endtask

   // Stimulus only: runs one read command against a slave that ends on beat last_idx.
   task automatic run_read(input logic [31:0] a, input logic [7:0] l, input int stall_at,
                           input int err_idx, input logic [1:0] err_resp, input int last_idx);
      int idx = 0;
      bit ar = 1'b0;
      clear_obs();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = l; cmd_burst = 2'b01;
      axi.RD_DATA_VALID = 1'b0;
      #1 obs_acc = cmd_ready;
      for (int cyc = 0; cyc < BOUND && !obs_done; cyc++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         rdata_ready = !(cyc >= stall_at && cyc < stall_at + 3);
         axi.RD_DATA_VALID = ar && idx <= last_idx;
         axi.RD_DATA_DATA = 32'hB000_0000 + idx;
         axi.RD_DATA_LAST = idx == last_idx;
         axi.RD_DATA_RESP = idx == err_idx ? err_resp : 2'b00;
         #1;
         if (axi.RD_ADDR_VALID && axi.RD_ADDR_READY) begin
            ar = 1'b1; obs_addr_hs++; obs_addr = axi.RD_ADDR_ADDR; obs_len = axi.RD_ADDR_LEN;
         end
         if (!rdata_ready && axi.RD_DATA_VALID) obs_stall++;
         if (!rdata_ready && axi.RD_DATA_READY !== 1'b0) obs_stall_err++;
         if (rdata_valid && rdata_ready) begin
            if (rdata !== 32'hB000_0000 + idx) obs_data_err++;
            obs_beats++;
            if (rdata_last) begin obs_last_cnt++; obs_last_at = obs_beats; end
         end
         if (axi.RD_DATA_VALID && axi.RD_DATA_READY) idx++;
         if (done_valid) begin obs_done = 1'b1; obs_resp = done_resp; obs_dw = done_write; end
      end
      axi.RD_DATA_VALID = 1'b0; rdata_ready = 1'b1;
      @(negedge clk); #1 obs_after = done_valid;
   endtask

   task automatic test_reset;
      rstn = 1'b1; #1; rstn = 1'b0; #1;
      n_chk++; if ({axi.WR_ADDR_VALID, axi.WR_DATA_VALID, axi.WR_BACK_READY, axi.RD_ADDR_VALID,
                    axi.RD_DATA_READY, rdata_valid, done_valid} !== 7'b0) begin
         n_fail++; $display("FAIL reset_outputs: got %b want 0000000", {axi.WR_ADDR_VALID,
            axi.WR_DATA_VALID, axi.WR_BACK_READY, axi.RD_ADDR_VALID, axi.RD_DATA_READY, rdata_valid, done_valid});
      end
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
      n_chk++; if (done_valid !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_valid); end
   endtask

   task automatic test_write_single;
      axi.WR_BACK_RESP = 2'b00; axi.WR_BACK_ID = 4'h0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4000_0001; cmd_len = 8'd0; cmd_burst = 2'b01;
      wdata = 32'h0010_0000; wdata_valid = 1'b1;
      #1;
      n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL single_cmd_ready: got %b want 1", cmd_ready); end
      @(negedge clk);
      cmd_write = 1'b0; cmd_addr = 32'h0;
      #1;
      n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL single_busy_ready: got %b want 0", cmd_ready); end
      n_chk++; if ({axi.WR_ADDR_VALID, axi.WR_ADDR_ADDR, axi.WR_ADDR_LEN, axi.WR_ADDR_ID} !== {1'b1, 32'h4000_0001, 8'd0, 4'h0}) begin
         n_fail++; $display("FAIL single_aw: got %b %h %h %h want 1 40000001 00 0", axi.WR_ADDR_VALID,
            axi.WR_ADDR_ADDR, axi.WR_ADDR_LEN, axi.WR_ADDR_ID);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      n_chk++; if ({axi.WR_DATA_VALID, axi.WR_DATA_LAST, wdata_ready, axi.WR_DATA_DATA} !== {3'b111, 32'h0010_0000}) begin
         n_fail++; $display("FAIL single_w: got %b%b%b %h want 111 00100000", axi.WR_DATA_VALID,
            axi.WR_DATA_LAST, wdata_ready, axi.WR_DATA_DATA);
      end
      @(negedge clk);
      wdata_valid = 1'b0;
      #1;
      n_chk++; if (axi.WR_BACK_READY !== 1'b1) begin n_fail++; $display("FAIL single_bready: got %b want 1", axi.WR_BACK_READY); end
      @(negedge clk); #1;
      n_chk++; if ({done_valid, done_write, done_resp} !== 4'b1100) begin
         n_fail++; $display("FAIL single_done: got %b%b%b want 1100", done_valid, done_write, done_resp);
      end
      @(negedge clk); #1;
      n_chk++; if ({done_valid, cmd_ready} !== 2'b01) begin
         n_fail++; $display("FAIL single_after: got done=%b ready=%b want 0 1", done_valid, cmd_ready);
      end
   endtask

   task automatic test_write_incr;
      run_write(32'h4000_0005, 8'd3, 1'b1, 2'b00, 4'h0);
      n_chk++; if ({obs_addr_hs, obs_addr, obs_len} !== {32'd1, 32'h4000_0005, 8'd3}) begin
         n_fail++; $display("FAIL incr_aw: got n=%0d %h %h want 1 40000005 03", obs_addr_hs, obs_addr, obs_len);
      end
      n_chk++; if ({obs_beats, obs_last_cnt, obs_last_at} !== {32'd4, 32'd1, 32'd4}) begin
         n_fail++; $display("FAIL incr_beats: got beats=%0d lasts=%0d at=%0d want 4 1 4", obs_beats, obs_last_cnt, obs_last_at);
      end
      n_chk++; if ({obs_data_err, obs_mirror_err} !== 64'd0) begin
         n_fail++; $display("FAIL incr_data: got data_err=%0d mirror_err=%0d want 0 0", obs_data_err, obs_mirror_err);
      end
      n_chk++; if ({obs_done, obs_dw, obs_resp, obs_after} !== 5'b11000) begin
         n_fail++; $display("FAIL incr_done: got %b%b%b%b want 1 1 00 0", obs_done, obs_dw, obs_resp, obs_after);
      end
   endtask

   task automatic test_write_errors;
      run_write(32'h4000_002B, 8'd0, 1'b0, 2'b10, 4'h0);
      n_chk++; if ({obs_done, obs_dw, obs_resp} !== 4'b1110) begin
         n_fail++; $display("FAIL bresp_err: got %b%b%b want 1 1 10", obs_done, obs_dw, obs_resp);
      end
      run_write(32'h4000_0000, 8'd0, 1'b0, 2'b00, 4'h5);
      n_chk++; if ({obs_done, obs_resp} !== 3'b110) begin
         n_fail++; $display("FAIL bid_mismatch: got %b%b want 1 10", obs_done, obs_resp);
      end
      axi.WR_BACK_ID = 4'h0;
   endtask

   task automatic test_read_stall;
      run_read(32'h4000_0010, 8'd9, 4, NONE, 2'b00, 9);
      n_chk++; if ({obs_addr_hs, obs_addr, obs_len} !== {32'd1, 32'h4000_0010, 8'd9}) begin
         n_fail++; $display("FAIL rstall_ar: got n=%0d %h %h want 1 40000010 09", obs_addr_hs, obs_addr, obs_len);
      end
      n_chk++; if ({obs_beats, obs_last_cnt, obs_last_at, obs_data_err} !== {32'd10, 32'd1, 32'd10, 32'd0}) begin
         n_fail++; $display("FAIL rstall_beats: got beats=%0d lasts=%0d at=%0d err=%0d want 10 1 10 0",
            obs_beats, obs_last_cnt, obs_last_at, obs_data_err);
      end
      n_chk++; if ({obs_stall, obs_stall_err} !== {32'd3, 32'd0}) begin
         n_fail++; $display("FAIL rstall_ready: got stalled=%0d leaks=%0d want 3 0", obs_stall, obs_stall_err);
      end
      n_chk++; if ({obs_done, obs_dw, obs_resp, obs_after} !== 5'b10000) begin
         n_fail++; $display("FAIL rstall_done: got %b%b%b%b want 1 0 00 0", obs_done, obs_dw, obs_resp, obs_after);
      end
   endtask

   task automatic test_read_err;
      run_read(32'h4000_0020, 8'd4, NONE, 2, 2'b10, 4);
      n_chk++; if ({obs_beats, obs_data_err, obs_last_at} !== {32'd5, 32'd0, 32'd5}) begin
         n_fail++; $display("FAIL rerr_beats: got beats=%0d err=%0d at=%0d want 5 0 5", obs_beats, obs_data_err, obs_last_at);
      end
      n_chk++; if ({obs_done, obs_resp} !== 3'b110) begin
         n_fail++; $display("FAIL rerr_resp: got %b%b want 1 10", obs_done, obs_resp);
      end
   endtask

   task automatic test_read_last_mismatch;
      run_read(32'h4000_0030, 8'd4, NONE, NONE, 2'b00, 1);
      n_chk++; if ({obs_beats, obs_last_cnt, obs_done, obs_resp} !== {32'd2, 32'd0, 3'b110}) begin
         n_fail++; $display("FAIL early_last: got beats=%0d lasts=%0d done=%b resp=%b want 2 0 1 10",
            obs_beats, obs_last_cnt, obs_done, obs_resp);
      end
      run_read(32'h4000_0040, 8'd4, NONE, NONE, 2'b00, 5);
      n_chk++; if ({obs_beats, obs_last_at, obs_done, obs_resp} !== {32'd6, 32'd5, 3'b110}) begin
         n_fail++; $display("FAIL missing_last: got beats=%0d at=%0d done=%b resp=%b want 6 5 1 10",
            obs_beats, obs_last_at, obs_done, obs_resp);
      end
   endtask

   task automatic test_read_max_len;
      run_read(32'h4000_0100, 8'hFF, NONE, NONE, 2'b00, 255);
      n_chk++; if ({obs_beats, obs_last_cnt, obs_last_at, obs_data_err} !== {32'd256, 32'd1, 32'd256, 32'd0}) begin
         n_fail++; $display("FAIL maxlen_beats: got beats=%0d lasts=%0d at=%0d err=%0d want 256 1 256 0",
            obs_beats, obs_last_cnt, obs_last_at, obs_data_err);
      end
      n_chk++; if ({obs_done, obs_resp} !== 3'b100) begin
         n_fail++; $display("FAIL maxlen_done: got %b%b want 1 00", obs_done, obs_resp);
      end
   endtask

   task automatic test_reset_mid_burst;
      int seen = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4000_0050; cmd_len = 8'd3; cmd_burst = 2'b01;
      wdata = 32'hC000_0000; wdata_valid = 1'b1; axi.WR_DATA_READY = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      wdata = 32'hC000_0001;
      #1;
      n_chk++; if (axi.WR_DATA_VALID !== 1'b1) begin n_fail++; $display("FAIL midrst_beat2: got %b want 1", axi.WR_DATA_VALID); end
      rstn = 1'b0;
      #1;
      n_chk++; if ({axi.WR_ADDR_VALID, axi.WR_DATA_VALID, axi.WR_BACK_READY, axi.RD_ADDR_VALID, wdata_ready,
                    cmd_ready, done_valid} !== 7'b0) begin
         n_fail++; $display("FAIL midrst_valids: got %b want 0000000", {axi.WR_ADDR_VALID, axi.WR_DATA_VALID,
            axi.WR_BACK_READY, axi.RD_ADDR_VALID, wdata_ready, cmd_ready, done_valid});
      end
      repeat (3) begin @(negedge clk); #1; if (done_valid) seen++; end
      wdata_valid = 1'b0;
      rstn = 1'b1;
      repeat (4) begin @(negedge clk); #1; if (done_valid) seen++; end
      n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses want 0", seen); end
      n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", cmd_ready); end
      run_read(32'h4000_0000, 8'd0, NONE, NONE, 2'b00, 0);
      n_chk++; if ({obs_acc, obs_beats, obs_last_at, obs_done, obs_dw, obs_resp} !== {1'b1, 32'd1, 32'd1, 4'b1000}) begin
         n_fail++; $display("FAIL midrst_read: got acc=%b beats=%0d at=%0d done=%b w=%b resp=%b want 1 1 1 1 0 00",
            obs_acc, obs_beats, obs_last_at, obs_done, obs_dw, obs_resp);
      end
   endtask

   initial begin
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_burst = 2'b01;
      wdata = '0; wdata_valid = 1'b0; rdata_ready = 1'b1;
      axi.WR_ADDR_READY = 1'b1; axi.WR_DATA_READY = 1'b1; axi.WR_BACK_VALID = 1'b1;
      axi.WR_BACK_ID = 4'h0; axi.WR_BACK_RESP = 2'b00;
      axi.RD_ADDR_READY = 1'b1; axi.RD_BACK_ID = 4'h0; axi.RD_DATA_DATA = '0;
      axi.RD_DATA_RESP = 2'b00; axi.RD_DATA_VALID = 1'b0; axi.RD_DATA_LAST = 1'b0;
      test_reset();
      test_write_single();
      test_write_incr();
      test_write_errors();
      test_read_stall();
      test_read_err();
      test_read_last_mismatch();
      test_read_max_len();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
